// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with req/gnt/rvalid data-memory port and MEM/WB register.
// Optional MEM_TIMEOUT_EN aborts an access that stays in REQ/WAIT for TIMEOUT_CYCLES cycles.
module mem_stage_lsu #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic              Branch_in,
    input  logic              ZERO_in,
    input  logic [DATA_W-1:0] ALU_OUT_in,
    input  logic [DATA_W-1:0] PC_Branch_in,
    input  logic [DATA_W-1:0] REG_DATA2_in,
    input  logic [4:0]        RD_in,
    output logic              PCSrc,
    output logic [DATA_W-1:0] PC_Branch_out,
    output logic              stall_mem,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              RegWrite_wb,
    output logic              MemtoReg_wb,
    output logic [DATA_W-1:0] READ_DATA_wb,
    output logic [DATA_W-1:0] ALU_OUT_wb,
    output logic [4:0]        RD_wb,
    output logic              mem_err_wb
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            r_state, w_next;
    logic              r_err, w_err_set, w_mem_op, w_misal, w_tmo, w_req;
    logic [DATA_W-1:0] r_rdata;

    assign w_mem_op      = MemRead_in | MemWrite_in;
    assign w_misal       = |ALU_OUT_in[1:0];
    assign PCSrc         = Branch_in & ZERO_in;
    assign PC_Branch_out = PC_Branch_in;
    assign stall_mem     = w_mem_op & (r_state != DONE);
    assign w_req         = (r_state == REQ) & ~w_tmo;
    assign dmem_req      = w_req;
    assign dmem_we       = w_req & MemWrite_in;
    assign dmem_addr     = ALU_OUT_in;
    assign dmem_wdata    = REG_DATA2_in;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          w_busy;
    assign w_busy = (r_state == REQ) | (r_state == WAIT);
    assign w_tmo  = w_busy & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_cnt <= '0;
        else        r_cnt <= w_busy ? r_cnt + 1'b1 : '0;
    end
`else
    assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

    // a store that sees gnt is complete; a load still owes its rvalid
    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            IDLE: if (w_mem_op) begin
                w_next    = w_misal ? DONE : REQ;
                w_err_set = w_misal;
            end
            REQ: if (w_tmo) begin
                w_next    = DONE;
                w_err_set = 1'b1;
            end else if (dmem_gnt) w_next = MemWrite_in ? DONE : WAIT;
            WAIT: if (w_tmo) begin
                w_next    = DONE;
                w_err_set = 1'b1;
            end else if (dmem_rvalid) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_set;
            if (r_state == WAIT && dmem_rvalid && !w_tmo) r_rdata <= dmem_rdata;
        end
    end

    // r_err is only ever set while in DONE, so it doubles as the done-with-error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite_wb  <= 1'b0;
            MemtoReg_wb  <= 1'b0;
            READ_DATA_wb <= '0;
            ALU_OUT_wb   <= '0;
            RD_wb        <= '0;
            mem_err_wb   <= 1'b0;
        end else if (stall_mem) begin
            RegWrite_wb <= 1'b0;
            mem_err_wb  <= 1'b0;
        end else begin
            RegWrite_wb  <= RegWrite_in & ~r_err;
            MemtoReg_wb  <= MemtoReg_in;
            READ_DATA_wb <= r_rdata;
            ALU_OUT_wb   <= ALU_OUT_in;
            RD_wb        <= RD_in;
            mem_err_wb   <= r_err;
        end
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs.
- Issues word loads and stores to the data memory over a req/gnt/rvalid handshake.
- Resolves the branch decision and registers the MEM/WB outputs.
- Drives `stall_mem`, which deasserts the EX/MEM `write` enable and freezes upstream stages while a memory access is outstanding.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT_CYCLES, 255, abort threshold in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- MemRead_in  in  1  EX/MEM load flag.
- MemWrite_in  in  1  EX/MEM store flag.
- MemtoReg_in  in  1  EX/MEM writeback-select.
- RegWrite_in  in  1  EX/MEM register-write flag.
- Branch_in  in  1  EX/MEM branch flag.
- ZERO_in  in  1  EX/MEM ALU zero.
- ALU_OUT_in  in  DATA_W  address / ALU result.
- PC_Branch_in  in  DATA_W  branch target.
- REG_DATA2_in  in  DATA_W  store data.
- RD_in  in  5  destination register.
- PCSrc  out  1  branch taken = Branch_in & ZERO_in (combinational).
- PC_Branch_out  out  DATA_W  pass-through of PC_Branch_in.
- stall_mem  out  1  1 while a memory op in EX/MEM is not completing this cycle.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  DATA_W  word address (ALU_OUT_in).
- dmem_wdata  out  DATA_W  store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  DATA_W  load data.
- RegWrite_wb  out  1  MEM/WB register-write flag.
- MemtoReg_wb  out  1  MEM/WB writeback-select.
- READ_DATA_wb  out  DATA_W  MEM/WB load data.
- ALU_OUT_wb  out  DATA_W  MEM/WB ALU result.
- RD_wb  out  5  MEM/WB destination register.
- mem_err_wb  out  1  MEM/WB error flag (misaligned or timeout).

Behaviour:
- Reset (reset=0, async): state=IDLE; all *_wb outputs, dmem_req and dmem_we go to 0 immediately. Counter cleared.
- mem_op = MemRead_in | MemWrite_in. If both are set, the op is treated as a store.
- FSM states are IDLE, REQ, WAIT, DONE.
- IDLE:
  - mem_op=0: no stall; MEM/WB captures inputs at the edge. Non-memory instructions therefore take 1 cycle with zero stall.
  - mem_op=1 and ALU_OUT_in[1:0]!=0: go to DONE with the error flag set; no memory request is issued.
  - mem_op=1 and aligned: go to REQ.
- REQ:
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata are driven from the EX/MEM inputs and held stable until gnt.
  - On gnt: store goes to DONE; load goes to WAIT.
- WAIT:
  - dmem_req=0.
  - On dmem_rvalid: capture dmem_rdata into an internal register; go to DONE.
  - rvalid is accepted only in WAIT and ignored in all other states.
- DONE:
  - stall_mem=0.
  - MEM/WB captures the EX/MEM fields plus the captured read data.
  - On error: RegWrite_wb forced to 0 and mem_err_wb=1.
  - Next state is IDLE unconditionally.
- stall_mem = mem_op & (state != DONE). This is combinational, so the stall is visible in the cycle the op arrives.
- While stall_mem=1, MEM/WB loads a bubble: RegWrite_wb=0, mem_err_wb=0, other fields don't-care but deterministic (hold).
- Minimum latencies:
  - Store: 3 cycles in EX/MEM (IDLE, REQ with gnt, DONE).
  - Load: 4 cycles (IDLE, REQ, WAIT with rvalid, DONE).
- Back-to-back memory ops: DONE→IDLE, then the new op proceeds IDLE→REQ. No request is ever issued twice for one op.
- Reset mid-operation:
  - dmem_req drops asynchronously; any later rvalid or gnt is ignored.
  - The memory may still complete an accepted store; no retry is made.
- PCSrc is combinational and unaffected by stall. Branches never stall.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - An 8+-bit counter (width sized for TIMEOUT_CYCLES) clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the count reaches TIMEOUT_CYCLES, the FSM goes to DONE with error set, RegWrite_wb=0 and mem_err_wb=1.
  - dmem_req drops on that cycle.
- When undefined: no counter; REQ and WAIT wait indefinitely, and mem_err_wb reports misalignment only.

Test Plan:
- ADD op (RegWrite_in=1, RD_in=5, ALU_OUT_in=0x10), no mem op → stall_mem=0; next edge RD_wb=5, ALU_OUT_wb=0x10, RegWrite_wb=1.
- Load from 0x100; gnt 2 cycles after req, rvalid 3 cycles later with 0xDEADBEEF → stall_mem high until DONE; READ_DATA_wb=0xDEADBEEF, MemtoReg_wb=1, exactly one req/gnt pair; bubbles (RegWrite_wb=0) during the stall.
- Store 0xCAFEF00D to 0x204 with gnt in the first REQ cycle → dmem_we=1, dmem_wdata=0xCAFEF00D; total stall 2 cycles; RegWrite_wb=0.
- Load from 0x102 → no dmem_req; mem_err_wb=1 and RegWrite_wb=0 at the DONE edge.
- Load outstanding in WAIT, reset pulsed low → dmem_req=0 and RegWrite_wb=0 immediately; a subsequent rvalid has no effect; state returns to IDLE.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, gnt never asserted → abort after 8 REQ cycles; mem_err_wb=1 and stall_mem released.
